load_store_unit: RTL and testbench

Memory-access stage of the RV32I core, directly downstream of the ALU. It takes the ALU's effective address (rs1 + offset) together with the load/store opcode and rs2 data, then runs a request/response handshake with data memory. Store data is steered onto byte lanes on the way out; load data is extracted, sign- or zero-extended and returned to writeback.

---
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage between the ALU and writeback.
//   Latches the effective address, opcode and rs2 on start, runs a req/ready
//   then rvalid handshake with data memory, lane-steers stores, extends loads.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   start, alu_code, addr,     access launch (sampled in IDLE only), opcode,
//   store_data                 effective address, rs2 value
//   busy, done, load_data      status, 1-cycle completion pulse, load result
//   misalign                   1-cycle pulse when a misaligned access is trapped
//   mem_req/we/addr/be/wdata   request channel to data memory (held until mem_ready)
//   mem_ready, mem_rvalid,     request accept, read data valid, read word
//   mem_rdata
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses without touching memory; otherwise misalign is tied 0 and the
// offending low address bits are ignored.
// The opcode values below mirror the core's define.vh ALU_* codes.

module load_store_unit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [5:0]  alu_code,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // FSM and registered outputs
  state_t      r_state;
  logic        r_done;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_load_data;

  // Access attributes kept for load extraction once the data returns
  logic [1:0]  r_off;
  size_t       r_size;
  logic        r_uns;

  // Opcode decode of the live inputs (only used on the launch edge)
  logic        w_is_mem;
  logic        w_is_load;
  logic        w_uns;
  size_t       w_size;

  always_comb begin
    w_is_mem  = 1'b1;
    w_is_load = 1'b1;
    w_uns     = 1'b0;
    w_size    = SZ_W;
    case (alu_code)
      ALU_LB:  w_size = SZ_B;
      ALU_LH:  w_size = SZ_H;
      ALU_LW:  w_size = SZ_W;
      ALU_LBU: begin w_size = SZ_B; w_uns = 1'b1; end
      ALU_LHU: begin w_size = SZ_H; w_uns = 1'b1; end
      ALU_SB:  begin w_size = SZ_B; w_is_load = 1'b0; end
      ALU_SH:  begin w_size = SZ_H; w_is_load = 1'b0; end
      ALU_SW:  begin w_size = SZ_W; w_is_load = 1'b0; end
      default: begin w_is_mem = 1'b0; w_is_load = 1'b0; end
    endcase
  end

  // Byte-lane enables and replicated write data. Replication lets memory pick
  // the active lanes purely from mem_be. Halfwords only look at addr[1], so an
  // odd halfword address (untrapped build) lands on its aligned halfword.
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign;
  assign w_misalign = ((w_size == SZ_H) && addr[0]) ||
                      ((w_size == SZ_W) && (addr[1:0] != 2'b00));
`endif

  // Load extraction from the returning word, using the latched offset/size
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      SZ_B:    w_load_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    w_load_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
      r_off       <= 2'd0;
      r_size      <= SZ_B;
      r_uns       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      // Pulses: cleared every cycle unless set below
      r_done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start && w_is_mem) begin
`ifdef LSU_MISALIGN_TRAP_EN
            // Trapped accesses complete immediately and never reach memory
            if (w_misalign) begin
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else
`endif
            begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= ~w_is_load;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_off       <= addr[1:0];
              r_size      <= w_size;
              r_uns       <= w_uns;
            end
          end
        end

        S_REQ: begin
          // Payload registers are untouched here, so they stay stable while stalled
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            r_load_data <= w_load_ext;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign load_data = r_load_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = r_misalign;
`else
  assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit.
//   Expected load_data values are queued when an access is launched and
//   popped when the DUT signals done; handshake timing is checked per cycle.

module tb_load_store_unit;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  alu_code = 6'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .alu_code   (alu_code),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, load_data, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("idle.done", 32'(done), 32'd0);
    end
  endtask

  // Launches one access at the current negedge and returns at the negedge of
  // the done cycle, so a following call starts in the same cycle done=1.
  task automatic access(input string nm, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] sd, input bit is_ld, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] eaddr,
                        input int stall, input int rdly, input logic [31:0] rdata,
                        input logic [31:0] eld, input bit poke);
    start = 1'b1; alu_code = code; addr = a; store_data = sd;
    if (is_ld) begin
      exp_q.push_back(eld);
      last_ld = eld;
    end else begin
      exp_q.push_back(last_ld);
    end
    @(negedge CLK);
    // cycle 1: scramble inputs so only latched values can appear
    start = 1'b0; alu_code = ALU_ADD; addr = 32'hFFFF_FFFF; store_data = 32'h0;
    chk({nm, ".req"},   32'(mem_req), 32'd1);
    chk({nm, ".busy"},  32'(busy),    32'd1);
    chk({nm, ".done1"}, 32'(done),    32'd0);
    chk({nm, ".we"},    32'(mem_we),  32'(!is_ld));
    chk({nm, ".addr"},  mem_addr,     eaddr);
    chk({nm, ".be"},    32'(mem_be),  32'(ebe));
    if (!is_ld) chk({nm, ".wdata"}, mem_wdata, ewd);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        // start while busy and rvalid during REQ must both be ignored
        start = 1'b1; alu_code = ALU_SW; addr = 32'h0000_0FFC; store_data = 32'h55;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      end
      @(negedge CLK);
      chk({nm, ".stall_req"},  32'(mem_req), 32'd1);
      chk({nm, ".stall_addr"}, mem_addr,     eaddr);
      chk({nm, ".stall_be"},   32'(mem_be),  32'(ebe));
      chk({nm, ".stall_we"},   32'(mem_we),  32'(!is_ld));
      chk({nm, ".stall_done"}, 32'(done),    32'd0);
    end
    start = 1'b0; alu_code = ALU_ADD; mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    if (!is_ld) begin
      chk({nm, ".done"},  32'(done), 32'd1);
      chk({nm, ".idle"},  32'(busy), 32'd0);
      sb_pop({nm, ".ld_hold"});
    end else begin
      chk({nm, ".wait_req"},  32'(mem_req), 32'd0);
      chk({nm, ".wait_busy"}, 32'(busy),    32'd1);
      chk({nm, ".wait_done"}, 32'(done),    32'd0);
      for (int i = 0; i < rdly; i++) begin
        @(negedge CLK);
        chk({nm, ".rdly_done"}, 32'(done), 32'd0);
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge CLK);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      chk({nm, ".done"}, 32'(done), 32'd1);
      chk({nm, ".idle"}, 32'(busy), 32'd0);
      sb_pop({nm, ".load_data"});
    end
    chk({nm, ".misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.done",      32'(done),      32'd0);
    chk("rst.misalign",  32'(misalign),  32'd0);
    chk("rst.mem_req",   32'(mem_req),   32'd0);
    chk("rst.mem_we",    32'(mem_we),    32'd0);
    chk("rst.mem_addr",  mem_addr,       32'd0);
    chk("rst.mem_be",    32'(mem_be),    32'd0);
    chk("rst.mem_wdata", mem_wdata,      32'd0);
    chk("rst.load_data", load_data,      32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    access("sw",  ALU_SW,  32'h100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 32'h100, 0, 0, 32'h0, 32'h0, 0);
    idle(1);
    // back-to-back chain: each start lands in the previous done cycle
    access("sb",  ALU_SB,  32'h203, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5, 32'h200, 0, 0, 32'h0, 32'h0, 0);
    access("sh",  ALU_SH,  32'h102, 32'h1234BEEF, 0, 4'b1100, 32'hBEEFBEEF, 32'h100, 0, 0, 32'h0, 32'h0, 0);
    access("lb",  ALU_LB,  32'h102, 32'h0,        1, 4'b0100, 32'h0,        32'h100, 0, 0, 32'h12F03456, 32'hFFFFFFF0, 0);
    access("lbu", ALU_LBU, 32'h102, 32'h0,        1, 4'b0100, 32'h0,        32'h100, 0, 0, 32'h12F03456, 32'h000000F0, 0);
    access("lh",  ALU_LH,  32'h002, 32'h0,        1, 4'b1100, 32'h0,        32'h000, 3, 1, 32'h80017FFF, 32'hFFFF8001, 1);
    access("lhu", ALU_LHU, 32'h000, 32'h0,        1, 4'b0011, 32'h0,        32'h000, 0, 0, 32'h80017FFF, 32'h00007FFF, 0);
    access("sw2", ALU_SW,  32'h040, 32'h01020304, 0, 4'b1111, 32'h01020304, 32'h040, 1, 0, 32'h0, 32'h0, 0);
    idle(1);

`ifdef LSU_MISALIGN_TRAP_EN
    start = 1'b1; alu_code = ALU_LW; addr = 32'h6; store_data = 32'h0;
    exp_q.push_back(last_ld);
    @(negedge CLK);
    start = 1'b0; alu_code = ALU_ADD;
    chk("lw_mis.misalign", 32'(misalign), 32'd1);
    chk("lw_mis.done",     32'(done),     32'd1);
    chk("lw_mis.req",      32'(mem_req),  32'd0);
    chk("lw_mis.busy",     32'(busy),     32'd0);
    sb_pop("lw_mis.ld_hold");
    @(negedge CLK);
    chk("lw_mis.pulse",    32'(misalign), 32'd0);
    chk("lw_mis.done2",    32'(done),     32'd0);
`else
    access("lw_mis", ALU_LW, 32'h006, 32'h0, 1, 4'b1111, 32'h0, 32'h004, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    idle(1);
`endif

    // Non-memory opcode with start is ignored
    start = 1'b1; alu_code = ALU_ADD; addr = 32'h40;
    @(negedge CLK);
    start = 1'b0;
    chk("nonmem.busy", 32'(busy),    32'd0);
    chk("nonmem.req",  32'(mem_req), 32'd0);
    chk("nonmem.done", 32'(done),    32'd0);
    idle(1);

    // Reset during WAIT abandons the load; late rvalid produces nothing
    start = 1'b1; alu_code = ALU_LW; addr = 32'h10;
    @(negedge CLK);
    start = 1'b0; alu_code = ALU_ADD;
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    chk("rstw.busy_before", 32'(busy), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rstw.busy",      32'(busy),     32'd0);
    chk("rstw.done",      32'(done),     32'd0);
    chk("rstw.mem_req",   32'(mem_req),  32'd0);
    chk("rstw.mem_we",    32'(mem_we),   32'd0);
    chk("rstw.mem_addr",  mem_addr,      32'd0);
    chk("rstw.mem_be",    32'(mem_be),   32'd0);
    chk("rstw.mem_wdata", mem_wdata,     32'd0);
    chk("rstw.load_data", load_data,     32'd0);
    chk("rstw.misalign",  32'(misalign), 32'd0);
    last_ld = 32'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge CLK);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("rstw.late_done", 32'(done), 32'd0);
    chk("rstw.late_busy", 32'(busy), 32'd0);
    chk("rstw.late_data", load_data, 32'd0);
    idle(1);

    access("post_rst", ALU_LBU, 32'h103, 32'h0, 1, 4'b1000, 32'h0, 32'h100, 0, 0, 32'h9A000000, 32'h0000009A, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
